// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce and valid/ready key output
module keypad_scanner #(
  parameter int SETTLE_CYCLES    = 4,
  parameter int DEBOUNCE_SAMPLES = 3
) (
  input  logic       my_clk,
  input  logic       my_reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam int            DW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    DB_TARGET  = 4'(DEBOUNCE_SAMPLES);

  typedef enum logic [1:0] {ST_SCAN, ST_PRESS_DB, ST_HELD} state_t;

  state_t        r_state;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col;
  logic [1:0]    r_row;
  logic [3:0]    r_cnt;
  logic [3:0]    r_code;
  logic          r_valid;
  logic          r_held;
  logic          r_ovf;

  state_t     w_state_nxt;
  logic [1:0] w_col_nxt;
  logic [1:0] w_row_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_held_nxt;
  logic       w_emit;
  logic       w_sample;
  logic       w_rows_idle;
  logic       w_row_hit;
  logic [1:0] w_low_row;
  logic [3:0] w_cnt_inc;
  logic [3:0] w_emit_code;

  assign w_sample    = (r_dwell == DWELL_LAST);
  assign w_rows_idle = (r_sync2 == 4'hF);
  assign w_row_hit   = ~r_sync2[r_row];
  assign w_cnt_inc   = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
  assign w_emit_code = {w_row_nxt, r_col};

  // Lowest active row wins when several keys share the driven column.
  always_comb begin
    w_low_row = 2'd3;
    if (!r_sync2[0])      w_low_row = 2'd0;
    else if (!r_sync2[1]) w_low_row = 2'd1;
    else if (!r_sync2[2]) w_low_row = 2'd2;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_held_nxt  = r_held;
    w_emit      = 1'b0;
    if (w_sample) begin
      case (r_state)
        ST_SCAN: begin
          if (!w_rows_idle) begin
            w_row_nxt = w_low_row;
            if (DB_TARGET <= 4'd1) begin
              w_emit      = 1'b1;
              w_held_nxt  = 1'b1;
              w_cnt_nxt   = 4'd0;
              w_state_nxt = ST_HELD;
            end else begin
              w_cnt_nxt   = 4'd1;
              w_state_nxt = ST_PRESS_DB;
            end
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end
        ST_PRESS_DB: begin
          if (w_row_hit) begin
            if (w_cnt_inc >= DB_TARGET) begin
              w_emit      = 1'b1;
              w_held_nxt  = 1'b1;
              w_cnt_nxt   = 4'd0;
              w_state_nxt = ST_HELD;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_cnt_nxt   = 4'd0;
            w_col_nxt   = r_col + 2'd1;
            w_state_nxt = ST_SCAN;
          end
        end
        ST_HELD: begin
          // Any non-idle sample restarts the release count: bounce or still pressed.
          if (w_rows_idle) begin
            if (w_cnt_inc >= DB_TARGET) begin
              w_held_nxt  = 1'b0;
              w_cnt_nxt   = 4'd0;
              w_col_nxt   = r_col + 2'd1;
              w_state_nxt = ST_SCAN;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_cnt_nxt = 4'd0;
          end
        end
        default: begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge my_clk or posedge my_reset) begin
    if (my_reset) begin
      r_state <= ST_SCAN;
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_dwell <= '0;
      r_col   <= 2'd0;
      r_row   <= 2'd0;
      r_cnt   <= 4'd0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync1 <= row_n;
      r_sync2 <= r_sync1;
      r_dwell <= w_sample ? '0 : r_dwell + DW'(1);
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_cnt   <= w_cnt_nxt;
      r_held  <= w_held_nxt;
    end
  end

  // Occupied output with no accept on the emitting edge drops the new key.
  always_ff @(posedge my_clk or posedge my_reset) begin
    if (my_reset) begin
      r_code  <= 4'd0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_emit) begin
      if (!r_valid || key_ready) begin
        r_code  <= w_emit_code;
        r_valid <= 1'b1;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (r_valid && key_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign col_n     = ~(4'b0001 << r_col);
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed-vector bench for keypad_scanner with a passive keypad model
module tb_keypad_scanner;

  logic        my_clk    = 1'b0;
  logic        my_reset  = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic        key_held;
  logic        overflow;
  logic [15:0] press     = 16'h0000;

  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   rises    = 0;
  int   act_cnt  = 0;
  logic prev_v   = 1'b0;

  always #5 my_clk = ~my_clk;

  keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_SAMPLES(3)) dut (
    .my_clk    (my_clk),
    .my_reset  (my_reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  // Pressed key (r,c) shorts row r to column c.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge my_clk) begin
    if (my_reset) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge my_clk) begin
    prev_v <= key_valid;
    if (key_valid && !prev_v) rises <= rises + 1;
    if (key_valid || key_held || overflow) act_cnt <= act_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge my_clk);
  endtask

  task automatic wait_col0(output int e);
    int n;
    n = 0;
    @(negedge my_clk);
    while (!(col_n == 4'b1110 && (cyc % 4) == 0) && n < 100) begin
      @(negedge my_clk);
      n++;
    end
    check("wait_col0", (n < 100), 1);
    e = cyc;
  endtask

  initial begin
    int         e;
    int         r0;
    logic [3:0] exp_col;

    // 1: reset values, free-running column rotation, quiet outputs
    #1 my_reset = 1'b1;
    #1;
    check("rst_col", col_n, 4'b1110);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_ovf", overflow, 0);
    @(negedge my_clk);
    @(negedge my_clk);
    #2 my_reset = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      wait_cyc(n);
      exp_col = ~(4'b0001 << ((n / 4) % 4));
      check("t1_col", col_n, exp_col);
    end
    wait_cyc(200);
    check("t1_quiet", act_cnt, 0);

    // 2: (r2,c1) held 20 samples, one accept pulse, release
    wait_col0(e);
    press = 16'h0200;
    wait_cyc(e + 15);
    check("t2_valid_early", key_valid, 0);
    r0 = rises;
    wait_cyc(e + 16);
    check("t2_valid", key_valid, 1);
    check("t2_code", key_code, 9);
    check("t2_held", key_held, 1);
    check("t2_col", col_n, 4'b1101);
    key_ready = 1'b1;
    wait_cyc(e + 17);
    check("t2_accept", key_valid, 0);
    key_ready = 1'b0;
    wait_cyc(e + 83);
    check("t2_lock_col", col_n, 4'b1101);
    check("t2_lock_held", key_held, 1);
    check("t2_one_emit", rises - r0, 1);
    wait_cyc(e + 84);
    press = 16'h0000;
    wait_cyc(e + 95);
    check("t2_held_late", key_held, 1);
    wait_cyc(e + 96);
    check("t2_release", key_held, 0);
    check("t2_resume_col", col_n, 4'b1011);
    check("t2_valid_end", key_valid, 0);

    // 3: short (r0,c3) press abandoned; release bounce restarts count
    wait_col0(e);
    r0 = rises;
    press = 16'h0008;
    wait_cyc(e + 20);
    press = 16'h0000;
    wait_cyc(e + 23);
    check("t3_locked_col", col_n, 4'b0111);
    wait_cyc(e + 24);
    check("t3_resume_col", col_n, 4'b1110);
    check("t3_no_valid", key_valid, 0);
    check("t3_no_held", key_held, 0);
    e = e + 24;
    press = 16'h0010;
    wait_cyc(e + 12);
    check("t3b_valid", key_valid, 1);
    check("t3b_code", key_code, 4);
    press = 16'h0000;
    wait_cyc(e + 20);
    press = 16'h0010;
    wait_cyc(e + 24);
    check("t3b_bounce_held", key_held, 1);
    press = 16'h0000;
    wait_cyc(e + 35);
    check("t3b_held_late", key_held, 1);
    wait_cyc(e + 36);
    check("t3b_release", key_held, 0);
    check("t3b_col", col_n, 4'b1101);
    check("t3b_code_kept", key_code, 4);
    check("t3_emits", rises - r0, 1);
    key_ready = 1'b1;
    wait_cyc(e + 37);
    check("t3b_accept", key_valid, 0);
    key_ready = 1'b0;

    // 5: accept on the same edge a new key (r1,c2) emits
    wait_col0(e);
    r0 = rises;
    press = 16'h0001;
    wait_cyc(e + 12);
    check("t5_first_valid", key_valid, 1);
    check("t5_first_code", key_code, 0);
    press = 16'h0000;
    wait_cyc(e + 24);
    check("t5_first_rel", key_held, 0);
    check("t5_col", col_n, 4'b1101);
    press = 16'h0040;
    wait_cyc(e + 39);
    check("t5_pre_valid", key_valid, 1);
    check("t5_pre_code", key_code, 0);
    key_ready = 1'b1;
    wait_cyc(e + 40);
    check("t5_code", key_code, 6);
    check("t5_valid", key_valid, 1);
    check("t5_ovf", overflow, 0);
    check("t5_held", key_held, 1);
    key_ready = 1'b0;
    press = 16'h0000;
    wait_cyc(e + 52);
    check("t5_rel", key_held, 0);
    check("t5_rel_col", col_n, 4'b0111);
    check("t5_valid_kept", key_valid, 1);
    check("t5_emits", rises - r0, 1);
    key_ready = 1'b1;
    wait_cyc(e + 53);
    check("t5_accept", key_valid, 0);
    key_ready = 1'b0;

    // 4: second key while output still occupied -> overflow
    wait_col0(e);
    press = 16'h0001;
    wait_cyc(e + 12);
    check("t4_valid", key_valid, 1);
    check("t4_code", key_code, 0);
    press = 16'h0000;
    wait_cyc(e + 24);
    check("t4_rel", key_held, 0);
    press = 16'h8000;
    wait_cyc(e + 43);
    check("t4_ovf_early", overflow, 0);
    wait_cyc(e + 44);
    check("t4_code_kept", key_code, 0);
    check("t4_valid_kept", key_valid, 1);
    check("t4_ovf", overflow, 1);
    check("t4_held", key_held, 1);
    press = 16'h0000;
    wait_cyc(e + 56);
    check("t4_rel2", key_held, 0);
    check("t4_rel2_col", col_n, 4'b1110);
    key_ready = 1'b1;
    wait_cyc(e + 57);
    check("t4_accept", key_valid, 0);
    check("t4_ovf_sticky", overflow, 1);
    key_ready = 1'b0;

    // 6: asynchronous reset in HELD with (r0,c1) kept pressed
    wait_col0(e);
    press = 16'h0002;
    wait_cyc(e + 16);
    check("t6_valid", key_valid, 1);
    check("t6_code", key_code, 1);
    check("t6_col", col_n, 4'b1101);
    #2 my_reset = 1'b1;
    #1;
    check("t6_rst_col", col_n, 4'b1110);
    check("t6_rst_code", key_code, 0);
    check("t6_rst_valid", key_valid, 0);
    check("t6_rst_held", key_held, 0);
    check("t6_rst_ovf", overflow, 0);
    @(negedge my_clk);
    @(negedge my_clk);
    #2 my_reset = 1'b0;
    wait_cyc(15);
    check("t6_no_early", key_valid, 0);
    check("t6_no_early_held", key_held, 0);
    wait_cyc(16);
    check("t6_valid_after", key_valid, 1);
    check("t6_code_after", key_code, 1);
    check("t6_held_after", key_held, 1);
    check("t6_ovf_after", overflow, 0);
    press = 16'h0000;
    repeat (4) @(negedge my_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
